// File: rtl/chip8_memory.sv
// CHIP-8 4 KiB byte RAM with boot sequencer: optional clear, fontset load, program loader, then CPU port.
// Build option: define CHIP8_MEM_CLEAR_EN to zero the whole RAM before the fontset is written.
module chip8_memory #(
    parameter logic [11:0] FONT_BASE = 12'h000,
    parameter logic [11:0] PROG_BASE = 12'h200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] address_in,
    input  logic [7:0]  data_in,
    input  logic        write_enable,
    output logic [7:0]  data_out,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        mem_ready
);

`ifdef CHIP8_MEM_CLEAR_EN
    localparam logic [1:0] S_CLEAR = 2'd0;
`endif
    localparam logic [1:0] S_FONT  = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_READY = 2'd3;
`ifdef CHIP8_MEM_CLEAR_EN
    localparam logic [1:0] S_INIT  = S_CLEAR;
`else
    localparam logic [1:0] S_INIT  = S_FONT;
`endif

    if (({1'b0, FONT_BASE} + 13'd79 > 13'h0FFF) ||
        ({1'b0, FONT_BASE} + 13'd79 >= {1'b0, PROG_BASE})) begin : g_bad_layout
        $error("chip8_memory: fontset must fit in RAM and lie below PROG_BASE");
    end

    // Byte idx of the 80-byte fontset; glyph rows are packed MSB-first in a 40-bit word.
    function automatic logic [7:0] font_byte(input logic [6:0] idx);
        logic [3:0]  glyph;
        logic [2:0]  row;
        logic [39:0] bits;
        glyph = 4'(idx / 7'd5);
        row   = 3'(idx - ({3'b000, glyph} * 7'd5));
        case (glyph)
            4'h0:    bits = 40'hF0_90_90_90_F0;
            4'h1:    bits = 40'h20_60_20_20_70;
            4'h2:    bits = 40'hF0_10_F0_80_F0;
            4'h3:    bits = 40'hF0_10_F0_10_F0;
            4'h4:    bits = 40'h90_90_F0_10_10;
            4'h5:    bits = 40'hF0_80_F0_10_F0;
            4'h6:    bits = 40'hF0_80_F0_90_F0;
            4'h7:    bits = 40'hF0_10_20_40_40;
            4'h8:    bits = 40'hF0_90_F0_90_F0;
            4'h9:    bits = 40'hF0_90_F0_10_F0;
            4'hA:    bits = 40'hF0_90_F0_90_90;
            4'hB:    bits = 40'hE0_90_E0_90_E0;
            4'hC:    bits = 40'hF0_80_80_80_F0;
            4'hD:    bits = 40'hE0_90_90_90_E0;
            4'hE:    bits = 40'hF0_80_F0_80_F0;
            4'hF:    bits = 40'hF0_80_F0_80_80;
            default: bits = 40'h00_00_00_00_00;
        endcase
        font_byte = 8'(bits >> (6'd32 - {row, 3'b000}));
    endfunction

    logic [1:0]  state_q, state_d;
    logic [11:0] ptr_q, ptr_d;
    logic [7:0]  data_out_q;
    logic [7:0]  mem_q [0:4095];
    logic        wr_en_s;
    logic [11:0] wr_addr_s;
    logic [7:0]  wr_data_s;

    // Single RAM write port, owned by the sequencer until ready, then by the CPU.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = ptr_q;
        wr_data_s = 8'h00;
        case (state_q)
`ifdef CHIP8_MEM_CLEAR_EN
            S_CLEAR: begin
                wr_en_s = 1'b1;
            end
`endif
            S_FONT: begin
                wr_en_s   = 1'b1;
                wr_addr_s = FONT_BASE + ptr_q;
                wr_data_s = font_byte(ptr_q[6:0]);
            end
            S_LOAD: begin
                wr_en_s   = load_valid;
                wr_data_s = load_data;
            end
            S_READY: begin
                wr_en_s   = ~write_enable;
                wr_addr_s = address_in;
                wr_data_s = data_in;
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    // Sequencer next state and pointer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
`ifdef CHIP8_MEM_CLEAR_EN
            S_CLEAR: begin
                if (ptr_q == 12'hFFF) begin
                    state_d = S_FONT;
                    ptr_d   = 12'h000;
                end else begin
                    ptr_d = ptr_q + 12'd1;
                end
            end
`endif
            S_FONT: begin
                if (ptr_q == 12'd79) begin
                    state_d = S_LOAD;
                    ptr_d   = PROG_BASE;
                end else begin
                    ptr_d = ptr_q + 12'd1;
                end
            end
            S_LOAD: begin
                // The top byte ends loading even without load_last; the pointer never wraps.
                if (load_valid && (load_last || (ptr_q == 12'hFFF))) begin
                    state_d = S_READY;
                end else if (load_valid) begin
                    ptr_d = ptr_q + 12'd1;
                end else begin
                    ptr_d = ptr_q;
                end
            end
            S_READY: begin
                state_d = S_READY;
            end
            default: begin
                state_d = S_INIT;
                ptr_d   = 12'h000;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            ptr_q   <= 12'h000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // RAM array; deliberately not reset, the sequencer initialises it.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
    end

    // Registered CPU read; a same-cycle write is seen only on the following read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q <= 8'h00;
        end else if (state_q == S_READY) begin
            data_out_q <= mem_q[address_in];
        end else begin
            data_out_q <= 8'h00;
        end
    end

    assign data_out   = data_out_q;
    assign load_ready = (state_q == S_LOAD);
    assign mem_ready  = (state_q == S_READY);

endmodule

// File: tb/tb_chip8_memory.sv
// Directed self-checking bench for chip8_memory; honours CHIP8_MEM_CLEAR_EN like the design.
module tb_chip8_memory;

`ifdef CHIP8_MEM_CLEAR_EN
    localparam int INIT_CYC = 4096 + 80;
`else
    localparam int INIT_CYC = 80;
`endif

    logic        clk;
    logic        reset;
    logic [11:0] address_in;
    logic [7:0]  data_in;
    logic        write_enable;
    logic [7:0]  data_out;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic        mem_ready;

    int errors;
    int checks;

    chip8_memory dut (
        .clk          (clk),
        .reset        (reset),
        .address_in   (address_in),
        .data_in      (data_in),
        .write_enable (write_enable),
        .data_out     (data_out),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .mem_ready    (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_read(input logic [11:0] addr, output logic [7:0] v);
        address_in   = addr;
        write_enable = 1'b1;
        tick();
        v = data_out;
    endtask

    task automatic push(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Pulse reset, then count cycles until the loader port opens.
    task automatic restart(input string name);
        int n;
        reset        = 1'b1;
        load_valid   = 1'b0;
        load_last    = 1'b0;
        write_enable = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n = 0;
        while (load_ready !== 1'b1 && n < INIT_CYC + 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== INIT_CYC) begin
            $display("FAIL %s init_cycles: got %0d expected %0d", name, n, INIT_CYC);
            errors++;
        end
    endtask

    task automatic test_reset();
        int n;
        reset        = 1'b1;
        address_in   = 12'h000;
        data_in      = 8'h00;
        write_enable = 1'b1;
        load_valid   = 1'b0;
        load_data    = 8'h00;
        load_last    = 1'b0;
        tick();
        checks++;
        if (data_out !== 8'h00 || load_ready !== 1'b0 || mem_ready !== 1'b0) begin
            $display("FAIL reset_outputs: got d=%h lr=%b mr=%b expected 00 0 0",
                     data_out, load_ready, mem_ready);
            errors++;
        end
        tick();
        reset = 1'b0;
        n = 0;
        while (load_ready !== 1'b1 && n < INIT_CYC + 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== INIT_CYC) begin
            $display("FAIL load_ready_rise: got %0d cycles expected %0d", n, INIT_CYC);
            errors++;
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (mem_ready !== 1'b0 || load_ready !== 1'b1 || data_out !== 8'h00) begin
            $display("FAIL idle_loader: got mr=%b lr=%b d=%h expected 0 1 00",
                     mem_ready, load_ready, data_out);
            errors++;
        end
    endtask

    task automatic test_load();
        logic [7:0]  v;
        logic [11:0] font_addr [0:7];
        logic [7:0]  font_exp  [0:7];
        font_addr = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h04B, 12'h04F, 12'h00A};
        font_exp  = '{8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0, 8'hF0, 8'h80, 8'hF0};
        push(8'h12, 1'b0);
        push(8'h34, 1'b0);
        checks++;
        if (mem_ready !== 1'b0) begin
            $display("FAIL early_ready: got %b expected 0", mem_ready);
            errors++;
        end
        push(8'h56, 1'b1);
        checks++;
        if (mem_ready !== 1'b1 || load_ready !== 1'b0) begin
            $display("FAIL ready_after_last: got mr=%b lr=%b expected 1 0", mem_ready, load_ready);
            errors++;
        end
        cpu_read(12'h200, v);
        checks++;
        if (v !== 8'h12) begin $display("FAIL prog_200: got %h expected 12", v); errors++; end
        cpu_read(12'h201, v);
        checks++;
        if (v !== 8'h34) begin $display("FAIL prog_201: got %h expected 34", v); errors++; end
        cpu_read(12'h202, v);
        checks++;
        if (v !== 8'h56) begin $display("FAIL prog_202: got %h expected 56", v); errors++; end
        for (int i = 0; i < 8; i++) begin
            cpu_read(font_addr[i], v);
            checks++;
            if (v !== font_exp[i]) begin
                $display("FAIL font_%h: got %h expected %h", font_addr[i], v, font_exp[i]);
                errors++;
            end
        end
    endtask

    task automatic test_read_during_write();
        address_in   = 12'h300;
        data_in      = 8'h5A;
        write_enable = 1'b0;
        tick();
        data_in = 8'hAB;
        tick();
        checks++;
        if (data_out !== 8'h5A) begin
            $display("FAIL rdw_old: got %h expected 5A", data_out);
            errors++;
        end
        write_enable = 1'b1;
        tick();
        checks++;
        if (data_out !== 8'hAB) begin
            $display("FAIL rdw_new: got %h expected AB", data_out);
            errors++;
        end
    endtask

    task automatic test_stall();
        logic [7:0] v;
        restart("stall");
        // CPU write attempt held low through the whole load must be ignored.
        address_in   = 12'h201;
        data_in      = 8'hEE;
        write_enable = 1'b0;
        load_valid = 1'b1; load_data = 8'hA1; load_last = 1'b0; tick();
        load_valid = 1'b0; load_data = 8'hFF; load_last = 1'b1; tick();
        load_valid = 1'b1; load_data = 8'hA2; load_last = 1'b0; tick();
        checks++;
        if (mem_ready !== 1'b0 || load_ready !== 1'b1 || data_out !== 8'h00) begin
            $display("FAIL stall_mid: got mr=%b lr=%b d=%h expected 0 1 00",
                     mem_ready, load_ready, data_out);
            errors++;
        end
        load_valid = 1'b0; load_data = 8'hFE; tick();
        load_valid = 1'b1; load_data = 8'hA3; load_last = 1'b1; tick();
        load_valid   = 1'b0;
        load_last    = 1'b0;
        write_enable = 1'b1;
        checks++;
        if (mem_ready !== 1'b1) begin
            $display("FAIL stall_ready: got %b expected 1", mem_ready);
            errors++;
        end
        cpu_read(12'h200, v);
        checks++;
        if (v !== 8'hA1) begin $display("FAIL stall_200: got %h expected A1", v); errors++; end
        cpu_read(12'h201, v);
        checks++;
        if (v !== 8'hA2) begin $display("FAIL stall_201: got %h expected A2", v); errors++; end
        cpu_read(12'h202, v);
        checks++;
        if (v !== 8'hA3) begin $display("FAIL stall_202: got %h expected A3", v); errors++; end
    endtask

    task automatic test_mid_reset();
        logic [7:0] v;
        cpu_read(12'h200, v);
        checks++;
        if (v !== 8'hA1) begin $display("FAIL pre_reset_read: got %h expected A1", v); errors++; end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'h00 || mem_ready !== 1'b0) begin
            $display("FAIL async_reset_ready: got d=%h mr=%b expected 00 0", data_out, mem_ready);
            errors++;
        end
        restart("mid_reset_a");
        push(8'hC1, 1'b0);
        push(8'hC2, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_ready !== 1'b0 || load_ready !== 1'b0 || data_out !== 8'h00) begin
            $display("FAIL async_reset_load: got mr=%b lr=%b d=%h expected 0 0 00",
                     mem_ready, load_ready, data_out);
            errors++;
        end
        restart("mid_reset_b");
        push(8'h77, 1'b1);
        cpu_read(12'h200, v);
        checks++;
        if (v !== 8'h77) begin $display("FAIL restart_200: got %h expected 77", v); errors++; end
    endtask

    task automatic test_end_of_mem();
        logic [7:0]  v;
        logic [11:0] a;
        restart("end_of_mem");
        for (int i = 0; i < 3584; i++) begin
            a          = 12'h200 + 12'(i);
            load_valid = 1'b1;
            load_data  = a[7:0] ^ 8'h5A;
            load_last  = 1'b0;
            tick();
            if (i == 3582) begin
                checks++;
                if (mem_ready !== 1'b0 || load_ready !== 1'b1) begin
                    $display("FAIL before_top: got mr=%b lr=%b expected 0 1", mem_ready, load_ready);
                    errors++;
                end
            end
        end
        checks++;
        if (mem_ready !== 1'b1 || load_ready !== 1'b0) begin
            $display("FAIL top_ends_load: got mr=%b lr=%b expected 1 0", mem_ready, load_ready);
            errors++;
        end
        load_data = 8'h99;
        tick();
        load_valid = 1'b0;
        cpu_read(12'hFFF, v);
        checks++;
        if (v !== 8'hA5) begin $display("FAIL top_byte: got %h expected A5", v); errors++; end
        cpu_read(12'h200, v);
        checks++;
        if (v !== 8'h5A) begin $display("FAIL first_byte: got %h expected 5A", v); errors++; end
        cpu_read(12'h000, v);
        checks++;
        if (v !== 8'hF0) begin $display("FAIL no_wrap_font: got %h expected F0", v); errors++; end
    endtask

`ifdef CHIP8_MEM_CLEAR_EN
    task automatic test_clear();
        logic [7:0] v;
        restart("clear");
        push(8'h42, 1'b1);
        cpu_read(12'hFFF, v);
        checks++;
        if (v !== 8'h00) begin $display("FAIL clear_fff: got %h expected 00", v); errors++; end
        cpu_read(12'h300, v);
        checks++;
        if (v !== 8'h00) begin $display("FAIL clear_300: got %h expected 00", v); errors++; end
        cpu_read(12'h200, v);
        checks++;
        if (v !== 8'h42) begin $display("FAIL clear_200: got %h expected 42", v); errors++; end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_load();
        test_read_during_write();
        test_stall();
        test_mid_reset();
        test_end_of_mem();
`ifdef CHIP8_MEM_CLEAR_EN
        test_clear();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
